// File: rtl/alu_ctrl.sv
// rtl/alu_ctrl.sv - round-robin request sequencer in front of the shared execute-stage ALU
// ALU_CTRL_FULL_SHIFT_EN: split 0-31 bit shifts into repeated ALU passes of at most CHUNK bits.
module alu_ctrl #(
    parameter int DATA_W = 32,
    parameter int OPC_W  = 5,
    parameter int CHUNK  = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [OPC_W-1:0]  req0_i,
    input  logic [DATA_W-1:0] req0_op1,
    input  logic [DATA_W-1:0] req0_op2,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [OPC_W-1:0]  req1_i,
    input  logic [DATA_W-1:0] req1_op1,
    input  logic [DATA_W-1:0] req1_op2,
    output logic              req1_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_id,
    input  logic              rsp_ready,
    output logic              alu_ex,
    output logic [OPC_W-1:0]  alu_i,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    input  logic [DATA_W-1:0] alu_res,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

    state_t            state, state_nx;
    logic              last_grant;
    logic              id;
    logic [OPC_W-1:0]  opc;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] op2;
    logic              grant0, grant1, accept;
    logic [OPC_W-1:0]  sel_opc;
    logic [DATA_W-1:0] sel_op1, sel_op2;

    // On a tie the requester that did not win last time is granted.
    assign grant0     = (state == IDLE) && req0_valid && (!req1_valid || last_grant);
    assign grant1     = (state == IDLE) && req1_valid && (!req0_valid || !last_grant);
    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign accept     = grant0 || grant1;
    assign sel_opc    = grant1 ? req1_i   : req0_i;
    assign sel_op1    = grant1 ? req1_op1 : req0_op1;
    assign sel_op2    = grant1 ? req1_op2 : req0_op2;

`ifdef ALU_CTRL_FULL_SHIFT_EN
    localparam logic [4:0] CHUNK_MAX = 5'(CHUNK);

    logic [4:0] rem, chunk, rem_nx;
    logic       shift_op, sel_shift;

    function automatic logic is_shift(input logic [OPC_W-1:0] o);
        return (o == OPC_W'(6)) || (o == OPC_W'(7)) || (o == OPC_W'(14));
    endfunction

    assign shift_op  = is_shift(opc);
    assign sel_shift = is_shift(sel_opc);
    assign chunk     = (rem > CHUNK_MAX) ? CHUNK_MAX : rem;
    assign rem_nx    = rem - chunk;
    assign alu_op2   = (state == ISSUE) ? (shift_op ? DATA_W'(chunk) : op2) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem <= '0;
        end else if (state == IDLE && accept) begin
            rem <= sel_shift ? sel_op2[4:0] : 5'd0;
        end else if (state == CAPTURE && shift_op) begin
            rem <= rem_nx;
        end
    end
`else
    assign alu_op2 = (state == ISSUE) ? op2 : '0;
`endif

    // All ALU-side and response outputs decode registered state only.
    assign alu_ex    = (state == ISSUE);
    assign alu_i     = (state == ISSUE) ? opc : '0;
    assign alu_op1   = (state == ISSUE) ? acc : '0;
    assign rsp_valid = (state == DONE);
    assign rsp_data  = (state == DONE) ? acc : '0;
    assign rsp_id    = (state == DONE) ? id : 1'b0;
    assign busy      = (state != IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = ISSUE;
            ISSUE:   state_nx = CAPTURE;
`ifdef ALU_CTRL_FULL_SHIFT_EN
            CAPTURE: state_nx = (shift_op && rem_nx != 5'd0) ? ISSUE : DONE;
`else
            CAPTURE: state_nx = DONE;
`endif
            DONE:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            id         <= 1'b0;
            opc        <= '0;
            acc        <= '0;
            op2        <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && accept) begin
                opc        <= sel_opc;
                acc        <= sel_op1;
                op2        <= sel_op2;
                id         <= grant1;
                last_grant <= grant1;
            end else if (state == CAPTURE) begin
                acc <= alu_res;
            end
        end
    end
endmodule
